seq_multiplier: RTL

Parametrised sequential shift-and-add multiplier. It is the multi-cycle successor to the team's 4-bit combinational multiplier in the integer ALU. It adds operand width generality, a signed/unsigned mode and a start/done handshake. It trades latency for area: one partial product per clock, with a registered 2*WIDTH-bit result.

---
 rtl/seq_multiplier.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock over
// WIDTH cycles, unsigned or two's-complement operands, start/done handshake.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            neg_r;

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             neg_s;
  logic [WIDTH:0]   sum_s;
  logic [PW-1:0]    next_acc_s;
  logic [PW-1:0]    result_s;

  // Operand magnitudes and result sign captured when a request is accepted
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
    neg_s   = 1'b0;
    if (signed_mode) begin
      if (a[WIDTH-1]) begin
        mag_a_s = ~a + WIDTH'(1'b1);
      end else begin
        mag_a_s = a;
      end
      if (b[WIDTH-1]) begin
        mag_b_s = ~b + WIDTH'(1'b1);
      end else begin
        mag_b_s = b;
      end
      neg_s = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      neg_s = 1'b0;
    end
  end

  // One shift-and-add step; the carry out of the upper half shifts back in
  always_comb begin
    sum_s = {1'b0, acc_r[PW-1:WIDTH]};
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[PW-1:WIDTH]};
    end
    next_acc_s = {sum_s, acc_r[WIDTH-1:1]};
    if (neg_r) begin
      result_s = ~next_acc_s + PW'(1'b1);
    end else begin
      result_s = next_acc_s;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mcand_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, FINISH: begin
          if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
            mcand_r <= mag_a_s;
            acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
            neg_r   <= neg_s;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= next_acc_s;
          cnt_r <= cnt_r + CW'(1'b1);
          if (cnt_r == LAST) begin
            state_r <= FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= result_s;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
